// File: rtl/id_scoreboard_if.sv
// Decode-to-issue bus for id_scoreboard.
// Groups the upstream decode handshake and payload, the downstream issue
// handshake and registered payload, the writeback release port, flush, and
// the stall/error status. slave = scoreboard side, master = surrounding pipe.
interface id_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  // upstream decode side
  logic            valid_i;
  logic            ack_o;
  logic [XLEN-1:0] instr_i;
  logic [XLEN-1:0] pc_i;
  logic [AW-1:0]   rd_i;
  logic [AW-1:0]   rs1a_i;
  logic [AW-1:0]   rs2a_i;
  logic            rd_we_i;
  logic            rs1_use_i;
  logic            rs2_use_i;
  logic [XLEN-1:0] rs1d_i;
  logic [XLEN-1:0] rs2d_i;
  logic [XLEN-1:0] imm_i;
  // downstream issue side
  logic            ack_i;
  logic            valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] rs1_o;
  logic [XLEN-1:0] rs2_o;
  logic [XLEN-1:0] imm_o;
  logic [AW-1:0]   rd_o;
  logic            rd_we_o;
  // writeback release, flush, status
  logic            wb_valid_i;
  logic [AW-1:0]   wb_rd_i;
  logic            flush_i;
  logic            stall_o;
  logic            err_o;

  modport slave (
    input  valid_i, instr_i, pc_i, rd_i, rs1a_i, rs2a_i, rd_we_i, rs1_use_i,
           rs2_use_i, rs1d_i, rs2d_i, imm_i, ack_i, wb_valid_i, wb_rd_i, flush_i,
    output ack_o, valid_o, instr_o, pc_o, rs1_o, rs2_o, imm_o, rd_o, rd_we_o,
           stall_o, err_o
  );

  modport master (
    output valid_i, instr_i, pc_i, rd_i, rs1a_i, rs2a_i, rd_we_i, rs1_use_i,
           rs2_use_i, rs1d_i, rs2d_i, imm_i, ack_i, wb_valid_i, wb_rd_i, flush_i,
    input  ack_o, valid_o, instr_o, pc_o, rs1_o, rs2_o, imm_o, rd_o, rd_we_o,
           stall_o, err_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard with a one-entry output register.
// Tracks outstanding writes per architectural register (x0 never tracked),
// blocks issue on RAW hazards and on WAW counter saturation, and forwards
// accepted instructions through a registered valid/ack stage.
// Ports:
//   clk   - rising-edge clock
//   rst_i - synchronous active-high reset
//   bus   - id_scoreboard_if.slave: decode in, issue out, wb release, flush,
//           ack_o/stall_o (combinational), err_o (sticky underflow)
module id_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_i,
  id_scoreboard_if.slave  bus
);
  localparam int unsigned AW     = $clog2(NREG);
  localparam int unsigned MAXCNT = (2 ** CNT_W) - 1;
  localparam int unsigned SUM_W  = CNT_W + 2;

  logic [CNT_W-1:0] r_cnt [NREG];
  logic             r_valid;
  logic             r_err;
  logic [XLEN-1:0]  r_instr;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1;
  logic [XLEN-1:0]  r_rs2;
  logic [XLEN-1:0]  r_imm;
  logic [AW-1:0]    r_rd;
  logic             r_rd_we;

  logic             w_hazard;
  logic             w_ack;
  logic             w_rel_held;
  logic [SUM_W-1:0] w_sum     [NREG];
  logic [1:0]       w_dec     [NREG];
  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_uflow;

  // Hazard check uses registered counters only; a same-cycle release does not bypass.
  always_comb begin
    w_hazard = 1'b0;
    if (bus.rs1_use_i && (bus.rs1a_i != '0) && (r_cnt[bus.rs1a_i] != '0)) w_hazard = 1'b1;
    if (bus.rs2_use_i && (bus.rs2a_i != '0) && (r_cnt[bus.rs2a_i] != '0)) w_hazard = 1'b1;
    if (bus.rd_we_i && (bus.rd_i != '0) && (r_cnt[bus.rd_i] == CNT_W'(MAXCNT))) w_hazard = 1'b1;
  end

  assign w_ack = bus.valid_i && (!r_valid || bus.ack_i) && !w_hazard && !bus.flush_i && !rst_i;

  // A flushed instruction still held here never reaches writeback, so release its rd now.
  assign w_rel_held = bus.flush_i && r_valid && !bus.ack_i && r_rd_we && (r_rd != '0);

  // Per-register next count: +1 claim, up to -2 release (wb + flushed hold), clamp at 0.
  always_comb begin
    w_uflow = '0;
    for (int i = 0; i < NREG; i++) begin
      w_sum[i]     = SUM_W'(r_cnt[i])
                   + SUM_W'(w_ack && bus.rd_we_i && (bus.rd_i == AW'(i)));
      w_dec[i]     = 2'(bus.wb_valid_i && (bus.wb_rd_i == AW'(i)))
                   + 2'(w_rel_held && (r_rd == AW'(i)));
      w_cnt_nxt[i] = r_cnt[i];
      if (i != 0) begin
        if (w_sum[i] < SUM_W'(w_dec[i])) begin
          w_cnt_nxt[i] = '0;
          w_uflow[i]   = 1'b1;
        end else begin
          w_cnt_nxt[i] = CNT_W'(w_sum[i] - SUM_W'(w_dec[i]));
        end
      end
    end
  end

  // Counters, sticky error and the output stage.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
      if (|w_uflow) r_err <= 1'b1;
      if (w_ack) begin
        r_valid <= 1'b1;
        r_instr <= bus.instr_i;
        r_pc    <= bus.pc_i;
        r_rs1   <= bus.rs1d_i;
        r_rs2   <= bus.rs2d_i;
        r_imm   <= bus.imm_i;
        r_rd    <= bus.rd_i;
        r_rd_we <= bus.rd_we_i;
      end else if (bus.ack_i || bus.flush_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.ack_o   = w_ack;
  assign bus.stall_o = bus.valid_i && !w_ack;
  assign bus.valid_o = r_valid;
  assign bus.err_o   = r_err;
  assign bus.instr_o = r_instr;
  assign bus.pc_o    = r_pc;
  assign bus.rs1_o   = r_rs1;
  assign bus.rs2_o   = r_rs2;
  assign bus.imm_o   = r_imm;
  assign bus.rd_o    = r_rd;
  assign bus.rd_we_o = r_rd_we;
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: scenario tasks plus an output scoreboard.
module tb_id_scoreboard;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd;
    logic            rd_we;
  } xact_t;

  logic  clk = 1'b0;
  logic  rst_i;
  int    errors = 0;
  int    checks = 0;
  int    seq = 0;
  xact_t exp_q[$];
  xact_t mon_obs;
  xact_t mon_exp;
  xact_t held;

  always #5 clk = ~clk;

  id_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

  id_scoreboard #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_i    = 1'b0;
    bus.instr_i    = '0;
    bus.pc_i       = '0;
    bus.rd_i       = '0;
    bus.rs1a_i     = '0;
    bus.rs2a_i     = '0;
    bus.rd_we_i    = 1'b0;
    bus.rs1_use_i  = 1'b0;
    bus.rs2_use_i  = 1'b0;
    bus.rs1d_i     = '0;
    bus.rs2d_i     = '0;
    bus.imm_i      = '0;
    bus.ack_i      = 1'b1;
    bus.wb_valid_i = 1'b0;
    bus.wb_rd_i    = '0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic drive_instr(input logic [AW-1:0] rd, input logic we,
                             input logic [AW-1:0] r1, input logic u1,
                             input logic [AW-1:0] r2, input logic u2);
    seq++;
    bus.valid_i   = 1'b1;
    bus.instr_i   = 32'h1000_0000 + 32'(seq);
    bus.pc_i      = 32'h8000_0000 + 32'(seq * 4);
    bus.rs1d_i    = {16'(seq), 16'hA5A5};
    bus.rs2d_i    = {16'h5A5A, 16'(seq)};
    bus.imm_i     = ~(32'h1000_0000 + 32'(seq));
    bus.rd_i      = rd;
    bus.rd_we_i   = we;
    bus.rs1a_i    = r1;
    bus.rs1_use_i = u1;
    bus.rs2a_i    = r2;
    bus.rs2_use_i = u2;
  endtask

  function automatic xact_t cur_xact();
    xact_t x;
    x.instr = bus.instr_i;
    x.pc    = bus.pc_i;
    x.rs1   = bus.rs1d_i;
    x.rs2   = bus.rs2d_i;
    x.imm   = bus.imm_i;
    x.rd    = bus.rd_i;
    x.rd_we = bus.rd_we_i;
    return x;
  endfunction

  // Output monitor: a transfer pops and compares; a flushed hold is discarded.
  always @(negedge clk) begin
    if (rst_i !== 1'b1 && bus.valid_o === 1'b1) begin
      if (bus.ack_i === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underrun: got instr %h, expected none", bus.instr_o);
        end else begin
          mon_exp       = exp_q.pop_front();
          mon_obs.instr = bus.instr_o;
          mon_obs.pc    = bus.pc_o;
          mon_obs.rs1   = bus.rs1_o;
          mon_obs.rs2   = bus.rs2_o;
          mon_obs.imm   = bus.imm_o;
          mon_obs.rd    = bus.rd_o;
          mon_obs.rd_we = bus.rd_we_o;
          if (mon_obs !== mon_exp) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", mon_obs, mon_exp);
          end
        end
      end else if (bus.flush_i === 1'b1 && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic test_reset();
    int bad;
    rst_i = 1'b1;
    idle_inputs();
    drive_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b, expected 0", bus.ack_o);
    end
    tick(); tick();
    checks++;
    if ({bus.valid_o, bus.err_o, bus.rd_we_o} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, expected 000", {bus.valid_o, bus.err_o, bus.rd_we_o});
    end
    checks++;
    if ({bus.instr_o, bus.pc_o, bus.rs1_o, bus.rs2_o, bus.imm_o, bus.rd_o} !== '0) begin
      errors++; $display("FAIL reset_data: instr %h pc %h rd %h, expected all 0", bus.instr_o, bus.pc_o, bus.rd_o);
    end
    bad = 0;
    for (int i = 0; i < NREG; i++) if (dut.r_cnt[i] !== 2'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_cnt: %0d nonzero counters, expected 0", bad);
    end
    rst_i = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        checks++;
        if (bus.valid_o !== 1'b1) begin
          errors++; $display("FAIL basic_latency[%0d]: got %b, expected 1", k, bus.valid_o);
        end
      end
      drive_instr(5'(10 + k), 1'b1, 5'(20 + k), 1'b1, 5'd0, 1'(k % 2));
      #1;
      checks++;
      if ({bus.ack_o, bus.stall_o} !== 2'b10) begin
        errors++; $display("FAIL basic_ack[%0d]: got %b, expected 10", k, {bus.ack_o, bus.stall_o});
      end
      held = cur_xact();
      exp_q.push_back(held);
      tick();
    end
    idle_inputs();
    tick();
    checks++;
    if ({bus.valid_o, bus.instr_o} !== {1'b0, held.instr}) begin
      errors++; $display("FAIL basic_drain: got %b/%h, expected 0/%h", bus.valid_o, bus.instr_o, held.instr);
    end
    bus.wb_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.wb_rd_i = 5'(10 + k);
      tick();
    end
    idle_inputs();
    checks++;
    if ({dut.r_cnt[10], dut.r_cnt[11], dut.r_cnt[12], dut.r_cnt[13], bus.err_o} !== 9'd0) begin
      errors++; $display("FAIL basic_release: cnt10..13 %0d %0d %0d %0d err %b, expected 0",
                         dut.r_cnt[10], dut.r_cnt[11], dut.r_cnt[12], dut.r_cnt[13], bus.err_o);
    end
  endtask

  task automatic test_raw();
    drive_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++; $display("FAIL raw_claim: got %b, expected 1", bus.ack_o);
    end
    exp_q.push_back(cur_xact());
    tick();
    drive_instr(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.stall_o, bus.ack_o} !== 2'b10) begin
        errors++; $display("FAIL raw_stall[%0d]: got %b, expected 10", c, {bus.stall_o, bus.ack_o});
      end
      tick();
    end
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd5;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL raw_no_bypass: got %b, expected 1", bus.stall_o);
    end
    tick();
    bus.wb_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++; $display("FAIL raw_release_ack: got %b, expected 1", bus.ack_o);
    end
    exp_q.push_back(cur_xact());
    tick();
    idle_inputs();
    tick();
    checks++;
    if (dut.r_cnt[5] !== 2'd0) begin
      errors++; $display("FAIL raw_cnt: got %0d, expected 0", dut.r_cnt[5]);
    end
  endtask

  task automatic test_waw();
    for (int k = 0; k < 3; k++) begin
      drive_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      checks++;
      if (bus.ack_o !== 1'b1) begin
        errors++; $display("FAIL waw_accept[%0d]: got %b, expected 1", k, bus.ack_o);
      end
      exp_q.push_back(cur_xact());
      tick();
    end
    drive_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if ({bus.stall_o, dut.r_cnt[7]} !== {1'b1, 2'd3}) begin
      errors++; $display("FAIL waw_saturate: stall %b cnt %0d, expected 1/3", bus.stall_o, dut.r_cnt[7]);
    end
    tick();
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd7;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL waw_release_cycle: got %b, expected 1", bus.stall_o);
    end
    tick();
    bus.wb_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++; $display("FAIL waw_fourth: got %b, expected 1", bus.ack_o);
    end
    exp_q.push_back(cur_xact());
    tick();
    idle_inputs();
    checks++;
    if (dut.r_cnt[7] !== 2'd3) begin
      errors++; $display("FAIL waw_cnt: got %0d, expected 3", dut.r_cnt[7]);
    end
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd7;
    tick(); tick(); tick();
    idle_inputs();
    checks++;
    if ({dut.r_cnt[7], bus.err_o} !== 3'b000) begin
      errors++; $display("FAIL waw_drain: cnt %0d err %b, expected 0/0", dut.r_cnt[7], bus.err_o);
    end
  endtask

  task automatic test_x0();
    int bad;
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd0;
    for (int k = 0; k < 5; k++) begin
      drive_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      #1;
      checks++;
      if ({bus.ack_o, bus.stall_o} !== 2'b10) begin
        errors++; $display("FAIL x0_issue[%0d]: got %b, expected 10", k, {bus.ack_o, bus.stall_o});
      end
      exp_q.push_back(cur_xact());
      tick();
    end
    idle_inputs();
    tick();
    bad = 0;
    for (int i = 0; i < NREG; i++) if (dut.r_cnt[i] !== 2'd0) bad++;
    checks++;
    if (bad != 0 || bus.err_o !== 1'b0) begin
      errors++; $display("FAIL x0_state: %0d nonzero counters err %b, expected 0/0", bad, bus.err_o);
    end
  endtask

  task automatic test_flush();
    bus.ack_i = 1'b0;
    drive_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++; $display("FAIL flush_accept: got %b, expected 1", bus.ack_o);
    end
    held = cur_xact();
    exp_q.push_back(held);
    tick();
    bus.valid_i = 1'b0;
    tick();
    drive_instr(5'd0, 1'b0, 5'd20, 1'b1, 5'd0, 1'b0);
    #1;
    checks++;
    if ({bus.valid_o, bus.instr_o, bus.ack_o, bus.stall_o, dut.r_cnt[9]} !== {1'b1, held.instr, 2'b01, 2'd1}) begin
      errors++; $display("FAIL flush_hold: v %b instr %h ack/stall %b%b cnt %0d, expected 1 %h 01 1",
                         bus.valid_o, bus.instr_o, bus.ack_o, bus.stall_o, dut.r_cnt[9], held.instr);
    end
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    checks++;
    if ({bus.valid_o, dut.r_cnt[9]} !== {1'b0, 2'd0}) begin
      errors++; $display("FAIL flush_kill: v %b cnt %0d, expected 0/0", bus.valid_o, dut.r_cnt[9]);
    end
    drive_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++; $display("FAIL flush_accept2: got %b, expected 1", bus.ack_o);
    end
    exp_q.push_back(cur_xact());
    tick();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    bus.ack_i   = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    checks++;
    if ({bus.valid_o, dut.r_cnt[9]} !== {1'b0, 2'd1}) begin
      errors++; $display("FAIL flush_with_ack: v %b cnt %0d, expected 0/1", bus.valid_o, dut.r_cnt[9]);
    end
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd9;
    tick();
    idle_inputs();
    checks++;
    if ({dut.r_cnt[9], bus.err_o} !== 3'b000) begin
      errors++; $display("FAIL flush_release: cnt %0d err %b, expected 0/0", dut.r_cnt[9], bus.err_o);
    end
  endtask

  task automatic test_same_cycle();
    drive_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    exp_q.push_back(cur_xact());
    tick();
    drive_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd3;
    #1;
    checks++;
    if (bus.ack_o !== 1'b1) begin
      errors++; $display("FAIL same_ack: got %b, expected 1", bus.ack_o);
    end
    exp_q.push_back(cur_xact());
    tick();
    idle_inputs();
    checks++;
    if ({dut.r_cnt[3], bus.err_o} !== {2'd1, 1'b0}) begin
      errors++; $display("FAIL same_cnt: cnt %0d err %b, expected 1/0", dut.r_cnt[3], bus.err_o);
    end
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd4;
    tick();
    idle_inputs();
    checks++;
    if ({bus.err_o, dut.r_cnt[4]} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL underflow: err %b cnt %0d, expected 1/0", bus.err_o, dut.r_cnt[4]);
    end
    tick(); tick();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b, expected 1", bus.err_o);
    end
    bus.ack_i = 1'b0;
    drive_instr(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    exp_q.push_back(cur_xact());
    tick();
    drive_instr(5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    rst_i = 1'b1;
    #1;
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_ack: got %b, expected 0", bus.ack_o);
    end
    tick();
    rst_i = 1'b0;
    idle_inputs();
    exp_q.delete();
    checks++;
    if ({bus.err_o, bus.valid_o, dut.r_cnt[3], dut.r_cnt[12], bus.instr_o} !== '0) begin
      errors++; $display("FAIL rst_mid_stall: err %b v %b cnt3 %0d cnt12 %0d instr %h, expected all 0",
                         bus.err_o, bus.valid_o, dut.r_cnt[3], dut.r_cnt[12], bus.instr_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_waw();
    test_x0();
    test_flush();
    test_same_cycle();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
